// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline stage: valid/ready handshake, optional skid entry,
// flush, registered writeback select and saturating stall counter.
module memwb_pipe_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int RWIDTH = 5,
    parameter int SKID   = 1,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [1:0]        memtoregin,
    input  logic              regwrin,
    input  logic              finin,
    input  logic [RWIDTH-1:0] regdstmuxin,
    input  logic [DWIDTH-1:0] aluoutin,
    input  logic [DWIDTH-1:0] dmdatain,
    input  logic [AWIDTH-1:0] pcnextin,
    input  logic              negativein,
    input  logic [31:0]       insin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        memtoregout,
    output logic              regwrout,
    output logic              finout,
    output logic [RWIDTH-1:0] regdstmuxout,
    output logic [DWIDTH-1:0] aluoutout,
    output logic [DWIDTH-1:0] dmdataout,
    output logic [AWIDTH-1:0] pcnextout,
    output logic              negativeout,
    output logic [31:0]       insout,
    output logic [DWIDTH-1:0] wbdataout,
    output logic [CWIDTH-1:0] stall_cnt
);

    typedef struct packed {
        logic [1:0]        memtoreg;
        logic              regwr;
        logic              fin;
        logic [RWIDTH-1:0] rd;
        logic [DWIDTH-1:0] alu;
        logic [DWIDTH-1:0] dm;
        logic [AWIDTH-1:0] pc;
        logic              neg;
        logic [31:0]       ins;
    } pl_t;

    pl_t               in_pl;
    pl_t               head_q, head_d;
    pl_t               skid_q, skid_d;
    logic              head_v_q, head_v_d;
    logic              skid_v_q, skid_v_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic              accept;
    logic              pop;
    logic [DWIDTH-1:0] pc_ext;

    // Bundle the incoming payload fields.
    always_comb begin
        in_pl          = '0;
        in_pl.memtoreg = memtoregin;
        in_pl.regwr    = regwrin;
        in_pl.fin      = finin;
        in_pl.rd       = regdstmuxin;
        in_pl.alu      = aluoutin;
        in_pl.dm       = dmdatain;
        in_pl.pc       = pcnextin;
        in_pl.neg      = negativein;
        in_pl.ins      = insin;
    end

    assign out_valid = head_v_q;
    assign in_ready  = (SKID != 0) ? ~skid_v_q
                                   : (~head_v_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign pop       = head_v_q & out_ready;

    // Head/skid occupancy and payload movement, oldest entry in head.
    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (pop) begin
            if (skid_v_q) begin
                head_d   = skid_q;
                skid_v_d = 1'b0;
                if (accept) begin
                    skid_d   = in_pl;
                    skid_v_d = 1'b1;
                end
            end else if (accept) begin
                head_d = in_pl;
            end else begin
                head_v_d = 1'b0;
            end
        end else if (accept) begin
            if (!head_v_q) begin
                head_d   = in_pl;
                head_v_d = 1'b1;
            end else begin
                skid_d   = in_pl;
                skid_v_d = 1'b1;
            end
        end
        if (flush) begin
            head_d   = head_q;
            skid_d   = skid_q;
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
        if (SKID == 0) begin
            skid_d   = '0;
            skid_v_d = 1'b0;
        end
    end

    // Back-pressure counter, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (head_v_q && !out_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + CWIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

    generate
        if (AWIDTH >= DWIDTH) begin : g_pc_trunc
            assign pc_ext = head_q.pc[DWIDTH-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(DWIDTH-AWIDTH){1'b0}}, head_q.pc};
        end
    endgenerate

    // Writeback data select from the head entry.
    always_comb begin
        wbdataout = '0;
        unique case (head_q.memtoreg)
            2'd0: wbdataout = head_q.alu;
            2'd1: wbdataout = head_q.dm;
            2'd2: wbdataout = pc_ext;
            2'd3: wbdataout = {{(DWIDTH-1){1'b0}}, head_q.neg};
        endcase
    end

    assign memtoregout  = head_q.memtoreg;
    assign regwrout     = head_q.regwr & head_v_q;
    assign finout       = head_q.fin & head_v_q;
    assign regdstmuxout = head_q.rd;
    assign aluoutout    = head_q.alu;
    assign dmdataout    = head_q.dm;
    assign pcnextout    = head_q.pc;
    assign negativeout  = head_q.neg;
    assign insout       = head_q.ins;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Directed bench for memwb_pipe_stage with a queue scoreboard.
// Three instances: default, CWIDTH=4, and SKID=0.
module tb_memwb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [1:0]  m2r_i;
    logic        regwr_i, fin_i, neg_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_i, dm_i, pc_i, ins_i;

    logic        in_ready, out_valid, regwrout, finout, negout;
    logic [1:0]  m2rout;
    logic [4:0]  rdout;
    logic [31:0] aluout, dmout, pcout, insout, wbout;
    logic [15:0] stall_cnt;

    logic        in_ready4, out_valid4, regwr4, fin4, neg4;
    logic [1:0]  m2r4;
    logic [4:0]  rd4;
    logic [31:0] alu4, dm4, pc4, ins4, wb4;
    logic [3:0]  stall4;

    logic        in_ready0, out_valid0, regwr0, fin0, neg0;
    logic [1:0]  m2r0;
    logic [4:0]  rd0;
    logic [31:0] alu0, dm0, pc0, ins0, wb0;
    logic [15:0] stall0;

    always #5 clk = ~clk;

    memwb_pipe_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .memtoregin(m2r_i), .regwrin(regwr_i),
        .finin(fin_i), .regdstmuxin(rd_i), .aluoutin(alu_i),
        .dmdatain(dm_i), .pcnextin(pc_i), .negativein(neg_i),
        .insin(ins_i), .out_valid(out_valid), .out_ready(out_ready),
        .memtoregout(m2rout), .regwrout(regwrout), .finout(finout),
        .regdstmuxout(rdout), .aluoutout(aluout), .dmdataout(dmout),
        .pcnextout(pcout), .negativeout(negout), .insout(insout),
        .wbdataout(wbout), .stall_cnt(stall_cnt)
    );

    memwb_pipe_stage #(.CWIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .flush(flush), .memtoregin(m2r_i), .regwrin(regwr_i),
        .finin(fin_i), .regdstmuxin(rd_i), .aluoutin(alu_i),
        .dmdatain(dm_i), .pcnextin(pc_i), .negativein(neg_i),
        .insin(ins_i), .out_valid(out_valid4), .out_ready(out_ready),
        .memtoregout(m2r4), .regwrout(regwr4), .finout(fin4),
        .regdstmuxout(rd4), .aluoutout(alu4), .dmdataout(dm4),
        .pcnextout(pc4), .negativeout(neg4), .insout(ins4),
        .wbdataout(wb4), .stall_cnt(stall4)
    );

    memwb_pipe_stage #(.SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .flush(flush), .memtoregin(m2r_i), .regwrin(regwr_i),
        .finin(fin_i), .regdstmuxin(rd_i), .aluoutin(alu_i),
        .dmdatain(dm_i), .pcnextin(pc_i), .negativein(neg_i),
        .insin(ins_i), .out_valid(out_valid0), .out_ready(out_ready),
        .memtoregout(m2r0), .regwrout(regwr0), .finout(fin0),
        .regdstmuxout(rd0), .aluoutout(alu0), .dmdataout(dm0),
        .pcnextout(pc0), .negativeout(neg0), .insout(ins0),
        .wbdataout(wb0), .stall_cnt(stall0)
    );

    typedef struct {
        logic [31:0] alu, dm, pc, ins;
        logic [1:0]  m2r;
        logic [4:0]  rd;
        logic        regwr, fin, neg;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_stall = 0;
    int   exp_stall4 = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] wb_of(input exp_t e);
        case (e.m2r)
            2'd0:    return e.alu;
            2'd1:    return e.dm;
            2'd2:    return e.pc;
            default: return {31'd0, e.neg};
        endcase
    endfunction

    task automatic set_in(input logic [31:0] a, d, p,
                          input logic [1:0] m, input logic r, f, n);
        alu_i = a; dm_i = d; pc_i = p; m2r_i = m;
        regwr_i = r; fin_i = f; neg_i = n;
        rd_i = a[4:0]; ins_i = ~a;
    endtask

    // Check the current outputs against the model, update, then clock.
    task automatic step();
        exp_t cur;
        bit   acc;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("stall_cnt", stall_cnt, exp_stall);
        chk("stall_cnt4", stall4, exp_stall4);
        if (q.size() > 0) begin
            chk("aluout", aluout, q[0].alu);
            chk("insout", insout, q[0].ins);
            chk("rdout", rdout, q[0].rd);
            chk("regwrout", regwrout, q[0].regwr);
            chk("finout", finout, q[0].fin);
            chk("wbdata", wbout, wb_of(q[0]));
        end else begin
            chk("regwrout_idle", regwrout, 1'b0);
            chk("finout_idle", finout, 1'b0);
        end
        cur.alu = alu_i; cur.dm = dm_i; cur.pc = pc_i; cur.ins = ins_i;
        cur.m2r = m2r_i; cur.rd = rd_i; cur.regwr = regwr_i;
        cur.fin = fin_i; cur.neg = neg_i;
        if (rst) begin
            q.delete();
            exp_stall  = 0;
            exp_stall4 = 0;
        end else begin
            if (q.size() > 0 && !out_ready) begin
                if (exp_stall < 65535) exp_stall++;
                if (exp_stall4 < 15) exp_stall4++;
            end
            if (flush) begin
                q.delete();
            end else begin
                acc = in_valid && (q.size() < 2);
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (acc) q.push_back(cur);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_regwr", regwrout, 1'b0);
        chk("rst_fin", finout, 1'b0);
        chk("rst_wbdata", wbout, 32'd0);
        chk("rst_alu", aluout, 32'd0);
        chk("rst_dm", dmout, 32'd0);
        chk("rst_pc", pcout, 32'd0);
        chk("rst_ins", insout, 32'd0);
        chk("rst_rd", rdout, 5'd0);
        chk("rst_m2r", m2rout, 2'd0);
        chk("rst_neg", negout, 1'b0);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    logic [31:0] wb_tbl [4];

    initial begin
        wb_tbl[0] = 32'hAAAA0000; wb_tbl[1] = 32'h5555;
        wb_tbl[2] = 32'h404;      wb_tbl[3] = 32'h1;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero();

        // Streaming at full rate.
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(32'h10 + i, 32'h100 + i, 32'h200 + i, 2'd0,
                   1'b1, 1'b0, 1'b0);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Back-pressure: A and B held, C refused.
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(32'hA0, 32'h1, 32'h2, 2'd1, 1'b1, 1'b0, 1'b1); step();
        set_in(32'hB0, 32'h3, 32'h4, 2'd2, 1'b0, 1'b1, 1'b0); step();
        set_in(32'hC0, 32'h5, 32'h6, 2'd3, 1'b1, 1'b1, 1'b1); step();
        in_valid = 1'b0;
        repeat (2) step();
        out_ready = 1'b1;
        repeat (3) step();

        // Flush with two entries held plus an incoming payload.
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(32'h51, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0); step();
        set_in(32'h52, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0); step();
        flush = 1'b1;
        set_in(32'hDEAD, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0); step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_regwr", regwrout, 1'b0);
        chk("flush_fin", finout, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        step();
        out_ready = 1'b1;
        repeat (2) step();

        // Writeback select sweep.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(32'hAAAA0000, 32'h5555, 32'h404, k[1:0],
                   1'b0, 1'b0, 1'b1);
            step();
            chk("wbsel", wbout, wb_tbl[k]);
        end
        in_valid = 1'b0;
        step();

        // Stall counter saturation on the 4-bit instance.
        out_ready = 1'b0; in_valid = 1'b1;
        set_in(32'h77, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step();
        in_valid = 1'b0;
        repeat (20) step();
        chk("stall4_sat", stall4, 4'd15);

        // Reset while the skid entry is full.
        in_valid = 1'b1;
        set_in(32'h81, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0); step();
        set_in(32'h82, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0); step();
        chk("full_in_ready", in_ready, 1'b0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        chk_zero();
        chk("rst_stall4", stall4, 4'd0);

        // Single-entry variant: in_ready tracks out_ready combinationally.
        in_valid = 1'b1;
        set_in(32'h91, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0); step();
        for (int t = 0; t < 4; t++) begin
            out_ready = t[0] ? 1'b0 : 1'b1;
            #1;
            chk("skid0_out_valid", out_valid0, 1'b1);
            chk("skid0_in_ready", in_ready0, out_ready);
            set_in(32'h92 + t, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memwb_pipe_stage.md
Name: memwb_pipe_stage

Overview:
- Parametrised MEM/WB pipeline stage that replaces the fixed free-running MEM/WB register.
- Adds a valid/ready handshake with an optional 2-entry skid buffer, flush (bubble insertion), and a synchronous reset.
- Adds a registered writeback-data select and a saturating back-pressure cycle counter.
- Sits between the MEM stage (upstream producer) and the register-file writeback/forwarding logic (downstream consumer).

Parameters:
- DWIDTH, 32, datapath width (ALU result, data memory word, writeback data).
- AWIDTH, 32, PC width.
- RWIDTH, 5, destination register index width.
- SKID, 1. 1 = 2-entry skid buffer, so in_ready depends only on registered state. 0 = single entry, in_ready combinational from out_ready.
- CWIDTH, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept the payload this cycle.
- flush  in  1  kill all held and incoming entries.
- memtoregin  in  2  writeback select: 0 ALU, 1 DM, 2 PC+4, 3 negative flag.
- regwrin  in  1  register write enable.
- finin  in  1  program-finished marker.
- regdstmuxin  in  RWIDTH  destination register.
- aluoutin  in  DWIDTH  ALU result.
- dmdatain  in  DWIDTH  data memory read data.
- pcnextin  in  AWIDTH  PC+4.
- negativein  in  1  negative flag.
- insin  in  32  instruction word.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head entry.
- memtoregout, regdstmuxout, aluoutout, dmdataout, pcnextout, negativeout, insout  out  as inputs  head entry payload.
- regwrout  out  1  head regwr AND out_valid.
- finout  out  1  head fin AND out_valid.
- wbdataout  out  DWIDTH  writeback data selected by memtoregout.
- stall_cnt  out  CWIDTH  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clock and reset:
  - Single clock clk; rst is synchronous, active-high, sampled at posedge.
  - On rst: head and skid valid clear, all payload registers 0, stall_cnt 0.
  - Hence out_valid=0, regwrout=0, finout=0, wbdataout=0, all payload outputs 0.
  - in_ready is 1 in the cycle after reset deasserts.
- Transfers:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Latency: 1 cycle, i.e. a payload accepted into an empty stage appears on the outputs the next cycle.
- Head entry:
  - Head loads from the input when accept and (head empty, or pop with skid empty).
  - Head loads from skid when pop and skid full; if accept occurs in the same cycle, the input goes to skid.
- Skid entry (SKID=1):
  - in_ready = ~skid_valid.
  - Input goes to skid when accept, head valid, and no pop.
  - Skid empties when its content moves to head.
  - At most 2 entries; entries leave in order of acceptance, no reordering.
- SKID=0: in_ready = ~out_valid | out_ready; the skid register is absent.
- Hold: while out_valid & ~out_ready, head payload is stable.
- When out_valid=0:
  - regwrout and finout are forced 0.
  - Other payload outputs hold their last value.
- flush:
  - Has highest priority after rst.
  - At the edge, head and skid valid clear and any accept in that cycle is discarded.
  - Payload registers are not required to clear.
  - in_ready is unaffected by flush in the flush cycle.
- wbdataout: combinational from head registers.
  - memtoreg 0 gives aluout.
  - memtoreg 1 gives dmdata.
  - memtoreg 2 gives pcnext, zero-extended or truncated to DWIDTH.
  - memtoreg 3 gives {DWIDTH-1 zeros, negative}.
- stall_cnt:
  - Increments when out_valid & ~out_ready.
  - Saturates at all-ones.
  - Cleared only by rst; flush does not clear it.

Test Plan:
- Reset then stream: rst 1 cycle, then in_valid=1 and out_ready=1 for 4 payloads with aluoutin=0x10..0x13 -> each appears on aluoutout 1 cycle later; out_valid=1 continuously; in_ready stays 1.
- Back-pressure with SKID=1: out_ready=0, push A then B.
  - Required: in_ready=0 after B; stall_cnt increments each stalled cycle.
  - Then out_ready=1: outputs show A, then B, then out_valid=0, with no loss or duplication.
- Flush: with 2 entries held (regwrin=1, finin=1), assert flush together with in_valid=1 -> next cycle out_valid=0, regwrout=0, finout=0, in_ready=1; the incoming payload is never output.
- Writeback select: aluout=0xAAAA0000, dmdata=0x5555, pcnext=0x404, negative=1, memtoreg swept 0..3 -> wbdataout = 0xAAAA0000, 0x5555, 0x404, 0x1.
- Saturation with CWIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 and stays at 15.
- Mid-operation reset: rst asserted while the skid is full -> next cycle all outputs 0, stall_cnt=0, in_ready=1.
- SKID=0 variant: out_valid=1 and out_ready toggled -> in_ready follows out_ready in the same cycle.
